// File: rtl/gradient_update_net_pkg.sv
// Shared types and helpers for the gradient update (SGD) stage.
package gradient_update_net_pkg;

    // Q8.8 sample data and the wide accumulator type
    typedef logic signed [15:0] data_type;
    typedef logic signed [31:0] double_data_type;

    localparam double_data_type DATA_MAX = 32'sd32767;
    localparam double_data_type DATA_MIN = -32'sd32768;

    // Clamp a wide value into the data_type range
    function automatic data_type sat16(input double_data_type v);
        data_type r;
        if (v > DATA_MAX) begin
            r = 16'sh7FFF;
        end else if (v < DATA_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/gradient_update_net_sat_sub_shift.sv
// Element-wise SGD step: nxt = sat(cur - (acc >>> SHIFT)).
module sat_sub_shift
    import gradient_update_net_pkg::*;
#(
    parameter int unsigned SHIFT = 2
) (
    input  data_type        cur_i,
    input  double_data_type acc_i,
    output data_type        nxt_o
);

    double_data_type step;
    double_data_type diff;

    // Arithmetic shift floors toward -inf; the 32-bit difference cannot
    // overflow because |step| is bounded by the 16-bit sample range.
    always_comb begin
        step  = acc_i >>> SHIFT;
        diff  = double_data_type'(cur_i) - step;
        nxt_o = sat16(diff);
    end

endmodule

// File: rtl/gradient_update_net.sv
// Mini-batch gradient accumulator with a shift-based SGD weight update.
module gradient_update_net
    import gradient_update_net_pkg::*;
#(
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 2,
    parameter int unsigned LOG2_BATCH = 2,
    parameter int unsigned LR_SHIFT   = 0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enable,
    input  logic     grad_valid,
    input  data_type dW     [0:ROWS-1][0:COLS-1],
    input  data_type db     [0:ROWS-1][0:0],
    input  logic     load_init,
    input  data_type W_init [0:ROWS-1][0:COLS-1],
    input  data_type b_init [0:ROWS-1][0:0],
    output data_type W      [0:ROWS-1][0:COLS-1],
    output data_type b      [0:ROWS-1][0:0],
    output logic     busy,
    output logic     update_done,
    output logic     overrun
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [15:0] LAST = 16'((32'd1 << LOG2_BATCH) - 32'd1);

    state_t          state_q, state_d;
    logic [15:0]     count_q, count_d;
    double_data_type accW_q [0:ROWS-1][0:COLS-1];
    double_data_type accW_d [0:ROWS-1][0:COLS-1];
    double_data_type accb_q [0:ROWS-1][0:0];
    double_data_type accb_d [0:ROWS-1][0:0];
    data_type        W_q    [0:ROWS-1][0:COLS-1];
    data_type        W_d    [0:ROWS-1][0:COLS-1];
    data_type        b_q    [0:ROWS-1][0:0];
    data_type        b_d    [0:ROWS-1][0:0];
    data_type        W_upd  [0:ROWS-1][0:COLS-1];
    data_type        b_upd  [0:ROWS-1][0:0];
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sat_sub_shift #(
                .SHIFT(LOG2_BATCH + LR_SHIFT)
            ) u_w (
                .cur_i(W_q[r][c]),
                .acc_i(accW_q[r][c]),
                .nxt_o(W_upd[r][c])
            );
        end
        sat_sub_shift #(
            .SHIFT(LOG2_BATCH + LR_SHIFT)
        ) u_b (
            .cur_i(b_q[r][0]),
            .acc_i(accb_q[r][0]),
            .nxt_o(b_upd[r][0])
        );
    end

    // Next-state logic: load_init overrides everything, enable gates the FSM
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accW_d  = accW_q;
        accb_d  = accb_q;
        W_d     = W_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        if (load_init) begin
            state_d = ST_ACCUM;
            count_d = '0;
            W_d     = W_init;
            b_d     = b_init;
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    accW_d[r][c] = '0;
                end
                accb_d[r][0] = '0;
            end
        end else if (enable) begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (grad_valid) begin
                        for (int unsigned r = 0; r < ROWS; r++) begin
                            for (int unsigned c = 0; c < COLS; c++) begin
                                accW_d[r][c] = accW_q[r][c] + double_data_type'(dW[r][c]);
                            end
                            accb_d[r][0] = accb_q[r][0] + double_data_type'(db[r][0]);
                        end
                        if (count_q == LAST) begin
                            count_d = '0;
                            state_d = ST_APPLY;
                        end else begin
                            count_d = count_q + 16'd1;
                        end
                    end
                end
                ST_APPLY: begin
                    W_d     = W_upd;
                    b_d     = b_upd;
                    done_d  = 1'b1;
                    ovr_d   = grad_valid;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        for (int unsigned c = 0; c < COLS; c++) begin
                            accW_d[r][c] = '0;
                        end
                        accb_d[r][0] = '0;
                    end
                    ovr_d   = grad_valid;
                    state_d = ST_ACCUM;
                end
                default: state_d = ST_ACCUM;
            endcase
        end
        busy_d = (state_d != ST_ACCUM);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    accW_q[r][c] <= '0;
                    W_q[r][c]    <= '0;
                end
                accb_q[r][0] <= '0;
                b_q[r][0]    <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            accW_q  <= accW_d;
            accb_q  <= accb_d;
            W_q     <= W_d;
            b_q     <= b_d;
        end
    end

    assign W           = W_q;
    assign b           = b_q;
    assign busy        = busy_q;
    assign update_done = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_gradient_update_net.sv
// Self-checking bench for gradient_update_net (2x2, batch 4, LR 1/4).
module tb_gradient_update_net;
    import gradient_update_net_pkg::*;

    localparam int L2B   = 2;
    localparam int LRS   = 2;
    localparam int BATCH = 1 << L2B;
    localparam int DIV   = 1 << (L2B + LRS);

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     enable = 1'b1;
    logic     grad_valid = 1'b0;
    logic     load_init = 1'b0;
    data_type dW     [0:1][0:1];
    data_type db     [0:1][0:0];
    data_type W_init [0:1][0:1];
    data_type b_init [0:1][0:0];
    data_type W      [0:1][0:1];
    data_type b      [0:1][0:0];
    logic     busy, update_done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int  mW [0:1][0:1];
    int  mb [0:1];
    int  sW [0:1][0:1];
    int  sb [0:1];
    int  m_n = 0;
    int  m_wait = 0;
    bit  e_busy = 0, e_done = 0, e_ovr = 0;

    gradient_update_net #(
        .ROWS(2), .COLS(2), .LOG2_BATCH(L2B), .LR_SHIFT(LRS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .grad_valid(grad_valid),
        .dW(dW), .db(db), .load_init(load_init), .W_init(W_init), .b_init(b_init),
        .W(W), .b(b), .busy(busy), .update_done(update_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgd(input int w, input int s);
        int step;
        int v;
        step = s / DIV;
        if (s < 0 && (s % DIV) != 0) step = step - 1;
        v = w - step;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Model: collect BATCH samples, then new weights appear two edges later
    always @(posedge clk) begin
        e_done = 0;
        e_ovr  = 0;
        if (reset || load_init) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    mW[r][c] = reset ? 0 : int'(W_init[r][c]);
                    sW[r][c] = 0;
                end
                mb[r] = reset ? 0 : int'(b_init[r][0]);
                sb[r] = 0;
            end
            m_n = 0;
            m_wait = 0;
        end else if (enable) begin
            if (m_wait == 0) begin
                if (grad_valid) begin
                    for (int r = 0; r < 2; r++) begin
                        for (int c = 0; c < 2; c++) sW[r][c] += int'(dW[r][c]);
                        sb[r] += int'(db[r][0]);
                    end
                    m_n++;
                    if (m_n == BATCH) begin
                        m_n = 0;
                        m_wait = 2;
                    end
                end
            end else begin
                e_ovr = grad_valid;
                if (m_wait == 2) begin
                    for (int r = 0; r < 2; r++) begin
                        for (int c = 0; c < 2; c++) begin
                            mW[r][c] = sgd(mW[r][c], sW[r][c]);
                            sW[r][c] = 0;
                        end
                        mb[r] = sgd(mb[r], sb[r]);
                        sb[r] = 0;
                    end
                    e_done = 1;
                end
                m_wait--;
            end
        end
        e_busy = (m_wait != 0);
    end

    // Compare every cycle once the first edge has happened
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++)
                    chk($sformatf("W[%0d][%0d]", r, c), int'(W[r][c]), mW[r][c]);
                chk($sformatf("b[%0d]", r), int'(b[r][0]), mb[r]);
            end
            chk("busy", int'(busy), int'(e_busy));
            chk("update_done", int'(update_done), int'(e_done));
            chk("overrun", int'(overrun), int'(e_ovr));
        end
    end

    task automatic set_grad(input int dwv, input int dbv, input bit spread);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) dW[r][c] = 16'(dwv + (spread ? 37 * (2 * r + c) : 0));
            db[r][0] = 16'(dbv - (spread ? 9 * r : 0));
        end
    endtask

    task automatic load(input int wv, input int bv);
        @(posedge clk); #2;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) W_init[r][c] = 16'(wv);
            b_init[r][0] = 16'(bv);
        end
        load_init = 1'b1;
        @(posedge clk); #2;
        load_init = 1'b0;
    endtask

    task automatic strobe(input int dwv, input int dbv, input bit spread);
        @(posedge clk); #2;
        set_grad(dwv, dbv, spread);
        grad_valid = 1'b1;
        @(posedge clk); #2;
        grad_valid = 1'b0;
    endtask

    // Called right after the final strobe of a batch has been accepted
    task automatic check_end(input string tag, input int w00, input int b0);
        chk({tag, " busy@+1"}, int'(busy), 1);
        chk({tag, " done@+1"}, int'(update_done), 0);
        @(posedge clk); #2;
        chk({tag, " done@+2"}, int'(update_done), 1);
        chk({tag, " W00"}, int'(W[0][0]), w00);
        chk({tag, " b0"}, int'(b[0][0]), b0);
        @(posedge clk); #2;
        chk({tag, " done@+3"}, int'(update_done), 0);
        chk({tag, " busy@+3"}, int'(busy), 0);
    endtask

    task automatic batch(input string tag, input int dwv, input int dbv, input bit spread,
                         input int w00, input int b0);
        for (int i = 0; i < BATCH; i++) strobe(dwv, dbv, spread);
        check_end(tag, w00, b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_grad(0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) W_init[r][c] = '0;
            b_init[r][0] = '0;
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk("reset W00", int'(W[0][0]), 0);
        chk("reset busy", int'(busy), 0);

        // basic SGD step: 0x0100 - 4*0x40/16 = 0x00F0, bias 0 + 16 = 0x0010
        load(16'h0100, 16'h0000);
        batch("basic", 16'h0040, 16'hFFC0, 1'b0, 16'h00F0, 16'h0010);

        // distinct per-element gradients, checked element-wise by the model
        load(16'h0100, 16'h0020);
        batch("spread", 16'h0040, 16'hFFC0, 1'b1, 16'h00F0, 16'h0030);

        // saturation: -32760 - 8191 clamps at -32768
        load(16'h8008, 16'h0000);
        batch("sat", 16'h7FFF, 16'h0000, 1'b0, -32768, 0);

        // negative floor: sum -4 >>> 4 = -1, so W = 0 + 1
        load(16'h0000, 16'h0000);
        batch("floor", 16'hFFFF, 16'hFFFF, 1'b0, 1, 1);

        // strobes during APPLY and DONE are dropped and flagged
        load(16'h0100, 16'h0000);
        for (int i = 0; i < BATCH; i++) strobe(16'h0040, 16'h0000, 1'b0);
        set_grad(16'h7FFF, 16'h7FFF, 1'b0);
        grad_valid = 1'b1;
        @(posedge clk); #2;
        chk("ovr apply", int'(overrun), 1);
        chk("ovr W00", int'(W[0][0]), 16'h00F0);
        @(posedge clk); #2;
        chk("ovr done", int'(overrun), 1);
        grad_valid = 1'b0;
        @(posedge clk); #2;
        chk("ovr clear", int'(overrun), 0);
        batch("after ovr", 16'h0040, 16'h0000, 1'b0, 16'h00E0, 0);

        // reset mid-batch, then a zero-gradient batch
        load(16'h0100, 16'h0100);
        strobe(16'h0040, 16'h0040, 1'b0);
        strobe(16'h0040, 16'h0040, 1'b0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        chk("midreset W00", int'(W[0][0]), 0);
        chk("midreset b0", int'(b[0][0]), 0);
        chk("midreset busy", int'(busy), 0);
        batch("zero", 16'h0000, 16'h0000, 1'b0, 0, 0);

        // load_init on the would-be final strobe cancels the batch
        load(16'h0200, 16'h0000);
        for (int i = 0; i < BATCH - 1; i++) strobe(16'h0040, 16'h0000, 1'b0);
        @(posedge clk); #2;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) W_init[r][c] = 16'h0300;
            b_init[r][0] = 16'h0000;
        end
        set_grad(16'h0040, 16'h0000, 1'b0);
        grad_valid = 1'b1;
        load_init = 1'b1;
        @(posedge clk); #2;
        grad_valid = 1'b0;
        load_init = 1'b0;
        chk("ldovr W00", int'(W[0][0]), 16'h0300);
        chk("ldovr busy", int'(busy), 0);
        chk("ldovr ovr", int'(overrun), 0);
        @(posedge clk); #2;
        chk("ldovr done", int'(update_done), 0);
        batch("after load", 16'h0040, 16'h0000, 1'b0, 16'h02F0, 0);

        // enable low: five strobes ignored, batch completes with the rest
        load(16'h0100, 16'h0000);
        strobe(16'h0040, 16'h0000, 1'b0);
        strobe(16'h0040, 16'h0000, 1'b0);
        @(posedge clk); #2;
        enable = 1'b0;
        set_grad(16'h7FFF, 16'h7FFF, 1'b0);
        grad_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        grad_valid = 1'b0;
        chk("disabled busy", int'(busy), 0);
        chk("disabled W00", int'(W[0][0]), 16'h0100);
        enable = 1'b1;
        strobe(16'h0040, 16'h0000, 1'b0);
        strobe(16'h0040, 16'h0000, 1'b0);
        check_end("enable", 16'h00F0, 0);

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
